mips_mc_ctrl: RTL and testbench
===============================

// Module: mips_mc_ctrl
// PURPOSE
//  Multi-cycle control FSM for the MIPS core. Sequences one shared ALU, one shared memory port and the register file
//  through IF/ID/EX/MEM/WB. Also handles variable-latency memory via a req/ack handshake.
//  Sits beside the datapath (PC, IR, MDR, A/B, ALUOut regs) and replaces the single-cycle control unit.
//  Also keeps cycle and retired-instruction counters.
// PARAMETERS
//  CNT_W    32  width of Cycle_cnt / Inst_cnt (wrap modulo 2^CNT_W)
// PORTS
//  clk          in   1      clock, all state on posedge
//  rst          in   1      synchronous, active-low reset
//  Opcode       in   6      IR[31:26], valid from ID onward
//  Zero         in   1      ALU zero flag, sampled in EX_BR
//  Mem_ack      in   1      memory completed current MemRead/MemWrite (may assert same cycle as request)
//  MemRead      out  1      memory read request, held until Mem_ack
//  MemWrite     out  1      memory write request, held until Mem_ack
//  IorD         out  1      0: address=PC, 1: address=ALUOut
//  IRWrite      out  1      load IR from Read_data
//  PC_en        out  1      load PC (unconditional or branch-taken)
//  PCSource     out  2      00 ALU result, 01 ALUOut (branch target), 10 jump target {PC[31:28],IR[25:0],2'b00}
//  ALUSrcA      out  1      0: PC, 1: A register
//  ALUSrcB      out  2      00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  ALUOp        out  2      00 add, 01 sub, 10 use funct (feeds existing ALU_control)
//  RegDst       out  1      0: rt, 1: rd
//  MemtoReg     out  1      0: ALUOut, 1: MDR
//  RegWrite     out  1      register file write enable
//  State        out  4      current state encoding (debug)
//  Cycle_cnt    out  CNT_W  cycles since reset
//  Inst_cnt     out  CNT_W  instructions retired since reset
// BEHAVIOUR
//  Opcodes: R 000000, j 000010, beq 000100, bne 000101, addiu 001001, lw 100011, sw 101011; others = nop.
//  Moore FSM; outputs decode from State only, except PC_en in EX_BR (uses Zero). Unlisted outputs = 0.
//  IF: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00. Stay until Mem_ack.
//   On the ack cycle: IRWrite=1, PC_en=1, PCSource=00 (PC+4), then go to ID.
//  ID: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
//   R->EX_R, addiu->EX_I, lw/sw->EX_ADDR, beq/bne->EX_BR, j->EX_J, unknown->IF (retires as nop).
//  EX_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> WB_R.   WB_R: RegDst=1, RegWrite=1 -> IF.
//  EX_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> WB_I.   WB_I: RegDst=0, RegWrite=1 -> IF.
//  EX_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEM_RD (lw) or MEM_WR (sw).
//  MEM_RD: MemRead=1, IorD=1; on Mem_ack -> WB_LD.   WB_LD: MemtoReg=1, RegWrite=1 -> IF.
//  MEM_WR: MemWrite=1, IorD=1; on Mem_ack -> IF.
//  EX_BR: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01.
//   PC_en = Zero for beq, ~Zero for bne. -> IF.
//  EX_J: PCSource=10, PC_en=1 -> IF.
//  Latency with zero-wait memory: R/addiu/sw 4 cycles, lw 5, branch/j 3, nop 2.
//   Each wait cycle adds 1.
//  Mem_ack is ignored outside IF/MEM_RD/MEM_WR. MemRead and MemWrite are never both 1.
//  Inst_cnt += 1 on the last cycle of each instruction (the cycle whose next state is IF).
//  Cycle_cnt += 1 every cycle rst=1. Both counters wrap.
//  Reset (rst=0 at posedge, any state, including mid-memory wait): State<=IF, counters<=0.
//   While rst=0, all control outputs are forced 0, so no memory request and no writes.
//   First fetch request appears in the cycle after rst rises.
// STRUCTURE
//  Shared header mips_defs.vh: opcode constants, state encodings,
//   ALUSrcB/PCSource/ALUOp encodings. The datapath uses the same header.
//  One sub-module: mips_perf_cnt (CNT_W counter pair, inc/clear inputs), instantiated once.
//  FSM state register plus combinational next-state/output decode remain in mips_mc_ctrl.
// TESTING
//  1 Reset: hold rst=0 3 cycles with Mem_ack=1 -> all outputs 0, counters 0.
//    Release -> MemRead=1, IorD=0 next cycle.
//  2 addiu, Mem_ack tied 1 -> states IF,ID,EX_I,WB_I. RegWrite=1 only in WB_I.
//    Inst_cnt=1, Cycle_cnt=4.
//  3 lw, memory 3-cycle latency on both accesses -> MemRead held 3 cycles in IF and in MEM_RD.
//    WB_LD has MemtoReg=1. Total 9 cycles.
//  4 bne Zero=0 -> PC_en=1, PCSource=01 in EX_BR. bne Zero=1 -> PC_en=0.
//    beq mirrors this. j -> PC_en=1, PCSource=10.
//  5 sw, then reset asserted during MEM_WR wait -> MemWrite drops to 0 at next edge.
//    State=IF, counters 0, and no RegWrite seen.
//  6 Opcode 111111 -> IF,ID,IF. No RegWrite/MemWrite. Inst_cnt increments.
//    Preload Cycle_cnt near 2^CNT_W-1 (CNT_W=4 build) -> wraps to 0.

Source files
------------

// File: rtl/mips_mc_ctrl_pkg.sv
// Purpose: shared encodings for the multi-cycle MIPS control path (opcodes, states, mux selects).
// Latency: n/a (constants, types and one helper function only).
// Backpressure: n/a.
package mips_mc_ctrl_pkg;

  // Opcode field IR[31:26]
  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALUOp handed to the existing ALU_control block
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EX_R    = 4'd2,
    S_WB_R    = 4'd3,
    S_EX_I    = 4'd4,
    S_WB_I    = 4'd5,
    S_EX_ADDR = 4'd6,
    S_MEM_RD  = 4'd7,
    S_WB_LD   = 4'd8,
    S_MEM_WR  = 4'd9,
    S_EX_BR   = 4'd10,
    S_EX_J    = 4'd11
  } state_e;

  // All control strobes/selects driven towards the datapath
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  // beq takes the branch on equal operands, bne on unequal ones
  function automatic logic branch_taken(input logic [5:0] opcode, input logic zero);
    return (opcode == OP_BNE) ? ~zero : zero;
  endfunction

endpackage

// File: rtl/mips_perf_cnt.sv
// Purpose: cycle / retired-instruction counter pair, both wrapping modulo 2^CNT_W.
// Latency: count visible one clock after the inc strobe.
// Backpressure: none; clr has priority over inc.
//  Ports: clk, clr (sync clear), cyc_inc, inst_inc, cycle_cnt, inst_cnt
module mips_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cyc_inc,
  input  logic             inst_inc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] inst_cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      if (cyc_inc)  cycle_cnt <= cycle_cnt + 1'b1;
      if (inst_inc) inst_cnt  <= inst_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Purpose: multi-cycle MIPS control FSM sequencing shared ALU, memory port and register file.
// Latency: R/addiu/sw 4 cycles, lw 5, branch/j 3, nop 2, plus one per memory wait cycle.
// Backpressure: memory stalls IF/MEM_RD/MEM_WR by withholding Mem_ack; requests held until acked.
//  Ports: clk, rst (sync, active-low), Opcode, Zero, Mem_ack in; datapath controls
//  (MemRead..RegWrite), debug State, Cycle_cnt and Inst_cnt out.
module mips_mc_ctrl
  import mips_mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Opcode,
  input  logic             Zero,
  input  logic             Mem_ack,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PC_en,
  output logic [1:0]       PCSource,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] Cycle_cnt,
  output logic [CNT_W-1:0] Inst_cnt
);

  state_e state, state_nxt;
  ctrl_t  ctrl;
  logic   retire;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IF;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IF;
    case (state)
      S_IF:      state_nxt = Mem_ack ? S_ID : S_IF;
      S_ID: begin
        case (Opcode)
          OP_R:          state_nxt = S_EX_R;
          OP_ADDIU:      state_nxt = S_EX_I;
          OP_LW, OP_SW:  state_nxt = S_EX_ADDR;
          OP_BEQ, OP_BNE: state_nxt = S_EX_BR;
          OP_J:          state_nxt = S_EX_J;
          default:       state_nxt = S_IF;   // unknown opcode retires as a nop
        endcase
      end
      S_EX_R:    state_nxt = S_WB_R;
      S_EX_I:    state_nxt = S_WB_I;
      S_EX_ADDR: state_nxt = (Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  state_nxt = Mem_ack ? S_WB_LD : S_MEM_RD;
      S_MEM_WR:  state_nxt = Mem_ack ? S_IF : S_MEM_WR;
      default:   state_nxt = S_IF;   // WB_*, EX_BR, EX_J and unused codes
    endcase
  end

  // Moore decode; only the IF ack cycle and EX_BR look at inputs.
  always_comb begin
    ctrl = '0;
    case (state)
      S_IF: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
        ctrl.alu_op    = ALUOP_ADD;
        if (Mem_ack) begin
          ctrl.ir_write  = 1'b1;
          ctrl.pc_en     = 1'b1;
          ctrl.pc_source = PCSRC_ALU;
        end
      end
      S_ID: begin
        // speculative branch target lands in ALUOut
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_EX_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_WB_R: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_EX_I, S_EX_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_WB_I:    ctrl.reg_write = 1'b1;
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_WB_LD: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EX_BR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
        ctrl.pc_en     = branch_taken(Opcode, Zero);
      end
      S_EX_J: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_en     = 1'b1;
      end
      default: ctrl = '0;
    endcase
    // Reset silences everything immediately, even mid memory wait.
    if (!rst) ctrl = '0;
  end

  // An IF that is still waiting loops to IF but has not finished anything.
  assign retire = rst && (state != S_IF) && (state_nxt == S_IF);

  mips_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
    .clk       (clk),
    .clr       (!rst),
    .cyc_inc   (rst),
    .inst_inc  (retire),
    .cycle_cnt (Cycle_cnt),
    .inst_cnt  (Inst_cnt)
  );

  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign IorD     = ctrl.iord;
  assign IRWrite  = ctrl.ir_write;
  assign PC_en    = ctrl.pc_en;
  assign PCSource = ctrl.pc_source;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign ALUOp    = ctrl.alu_op;
  assign RegDst   = ctrl.reg_dst;
  assign MemtoReg = ctrl.mem_to_reg;
  assign RegWrite = ctrl.reg_write;
  assign State    = state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Purpose: self-checking bench for mips_mc_ctrl (32-bit and 4-bit counter builds side by side).
// Latency: n/a.
// Backpressure: memory latency modelled by driving Mem_ack per cycle.
module tb_mips_mc_ctrl;
  import mips_mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic       Zero = 1'b0;
  logic       Mem_ack = 1'b0;

  logic        MemRead, MemWrite, IorD, IRWrite, PC_en, ALUSrcA, RegDst, MemtoReg, RegWrite;
  logic [1:0]  PCSource, ALUSrcB, ALUOp;
  logic [3:0]  State;
  logic [31:0] Cycle_cnt, Inst_cnt;

  logic        w4_MemRead, w4_MemWrite, w4_IorD, w4_IRWrite, w4_PC_en, w4_ALUSrcA;
  logic        w4_RegDst, w4_MemtoReg, w4_RegWrite;
  logic [1:0]  w4_PCSource, w4_ALUSrcB, w4_ALUOp;
  logic [3:0]  w4_State;
  logic [3:0]  w4_Cycle_cnt, w4_Inst_cnt;

  logic [14:0] ctrl_bus, w4_ctrl_bus;
  assign ctrl_bus = {MemRead, MemWrite, IorD, IRWrite, PC_en, PCSource, ALUSrcA,
                     ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite};
  assign w4_ctrl_bus = {w4_MemRead, w4_MemWrite, w4_IorD, w4_IRWrite, w4_PC_en, w4_PCSource,
                        w4_ALUSrcA, w4_ALUSrcB, w4_ALUOp, w4_RegDst, w4_MemtoReg, w4_RegWrite};

  mips_mc_ctrl #(.CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Zero(Zero), .Mem_ack(Mem_ack),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .PC_en(PC_en), .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .State(State), .Cycle_cnt(Cycle_cnt), .Inst_cnt(Inst_cnt)
  );

  mips_mc_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Zero(Zero), .Mem_ack(Mem_ack),
    .MemRead(w4_MemRead), .MemWrite(w4_MemWrite), .IorD(w4_IorD), .IRWrite(w4_IRWrite),
    .PC_en(w4_PC_en), .PCSource(w4_PCSource), .ALUSrcA(w4_ALUSrcA), .ALUSrcB(w4_ALUSrcB),
    .ALUOp(w4_ALUOp), .RegDst(w4_RegDst), .MemtoReg(w4_MemtoReg), .RegWrite(w4_RegWrite),
    .State(w4_State), .Cycle_cnt(w4_Cycle_cnt), .Inst_cnt(w4_Inst_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One instruction run with zero-wait memory.
  //  seq : state codes, cycle 0 in [3:0]
  //  last: {PC_en, PCSource, RegWrite, RegDst, MemtoReg, MemWrite, MemRead, IorD} on final cycle
  //  alu : {ALUSrcA, ALUSrcB, ALUOp} on cycle 2 (cycle 1 for two-cycle instructions)
  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        zero;
    int          ncyc;
    logic [19:0] seq;
    logic [8:0]  last;
    logic [4:0]  alu;
  } vec_t;

  vec_t vq[$];
  vec_t sb_q[$];

  task automatic add_vec(input string name, input logic [5:0] op, input logic zero, input int ncyc,
                         input logic [19:0] seq, input logic [8:0] last, input logic [4:0] alu);
    vec_t v;
    v.name = name; v.op = op; v.zero = zero; v.ncyc = ncyc;
    v.seq = seq; v.last = last; v.alu = alu;
    vq.push_back(v);
  endtask

  task automatic reset_dut(input int n);
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        v, e;
    logic [31:0] c0, i0;
    logic        early_wr;
    int          alu_idx;
    logic [8:0]  lw_ack, lw_rd, lw_irw, lw_iord, lw_m2r;
    logic [35:0] lw_seq;

    add_vec("addiu",   OP_ADDIU,  1'b0, 4, 20'h05410, 9'b0_00_1_0_0_0_0_0, 5'b1_10_00);
    add_vec("rtype",   OP_R,      1'b0, 4, 20'h03210, 9'b0_00_1_1_0_0_0_0, 5'b1_00_10);
    add_vec("lw",      OP_LW,     1'b0, 5, 20'h87610, 9'b0_00_1_0_1_0_0_0, 5'b1_10_00);
    add_vec("sw",      OP_SW,     1'b0, 4, 20'h09610, 9'b0_00_0_0_0_1_0_1, 5'b1_10_00);
    add_vec("beq_z1",  OP_BEQ,    1'b1, 3, 20'h00A10, 9'b1_01_0_0_0_0_0_0, 5'b1_00_01);
    add_vec("beq_z0",  OP_BEQ,    1'b0, 3, 20'h00A10, 9'b0_01_0_0_0_0_0_0, 5'b1_00_01);
    add_vec("bne_z0",  OP_BNE,    1'b0, 3, 20'h00A10, 9'b1_01_0_0_0_0_0_0, 5'b1_00_01);
    add_vec("bne_z1",  OP_BNE,    1'b1, 3, 20'h00A10, 9'b0_01_0_0_0_0_0_0, 5'b1_00_01);
    add_vec("jump",    OP_J,      1'b0, 3, 20'h00B10, 9'b1_10_0_0_0_0_0_0, 5'b0_00_00);
    add_vec("nop_3f",  6'b111111, 1'b0, 2, 20'h00010, 9'b0_00_0_0_0_0_0_0, 5'b0_11_00);
    add_vec("nop_08",  6'b001000, 1'b1, 2, 20'h00010, 9'b0_00_0_0_0_0_0_0, 5'b0_11_00);

    // ---- Reset behaviour, with Mem_ack held high throughout ----
    rst = 1'b0; Mem_ack = 1'b1; Opcode = OP_LW;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ctrl", ctrl_bus, 15'd0);
      check("rst_ctrl_w4", w4_ctrl_bus, 15'd0);
      check("rst_state", State, S_IF);
      check("rst_cycle", Cycle_cnt, 32'd0);
      check("rst_inst", Inst_cnt, 32'd0);
      tick();
    end
    rst = 1'b1; Mem_ack = 1'b0;
    @(negedge clk);
    check("rel_fetch", {MemRead, IorD, MemWrite}, 3'b100);
    tick();
    check("rel_wait_state", State, S_IF);
    check("rel_cycle", Cycle_cnt, 32'd1);
    check("rel_inst", Inst_cnt, 32'd0);

    // ---- Table-driven single instructions, zero-wait memory ----
    Mem_ack = 1'b1;
    reset_dut(2);
    for (int k = 0; k < vq.size(); k++) begin
      v = vq[k];
      c0 = Cycle_cnt; i0 = Inst_cnt;
      Opcode = v.op; Zero = v.zero; Mem_ack = 1'b1;
      sb_q.push_back(v);
      early_wr = 1'b0;
      alu_idx = (v.ncyc >= 3) ? 2 : 1;
      for (int i = 0; i < v.ncyc; i++) begin
        @(negedge clk);
        check({v.name, "_state"}, State, v.seq[4*i +: 4]);
        check({v.name, "_rdwr_excl"}, MemRead & MemWrite, 1'b0);
        if (i == 0)
          check({v.name, "_if"}, {MemRead, IorD, IRWrite, PC_en, PCSource, ALUSrcA, ALUSrcB, ALUOp},
                11'b1_0_1_1_00_0_01_00);
        if (i == alu_idx)
          check({v.name, "_alu"}, {ALUSrcA, ALUSrcB, ALUOp}, v.alu);
        if (i == v.ncyc - 1)
          check({v.name, "_last"}, {PC_en, PCSource, RegWrite, RegDst, MemtoReg, MemWrite, MemRead, IorD},
                v.last);
        else if (RegWrite || MemWrite)
          early_wr = 1'b1;
        tick();
      end
      e = sb_q.pop_front();
      check({e.name, "_ret_state"}, State, S_IF);
      check({e.name, "_inst_delta"}, Inst_cnt - i0, 32'd1);
      check({e.name, "_cycle_delta"}, Cycle_cnt - c0, e.ncyc);
      check({e.name, "_early_write"}, early_wr, 1'b0);
      if (k == 0) begin
        check("first_inst_cnt", Inst_cnt, 32'd1);
        check("first_cycle_cnt", Cycle_cnt, 32'd4);
      end
    end

    // ---- lw with 3-cycle memory latency on fetch and load; ack in ID/EX must be ignored ----
    lw_ack  = 9'b110011100;
    lw_seq  = 36'h877761000;
    lw_rd   = 9'b011100111;
    lw_irw  = 9'b000000100;
    lw_iord = 9'b011100000;
    lw_m2r  = 9'b100000000;
    c0 = Cycle_cnt; i0 = Inst_cnt;
    Opcode = OP_LW;
    for (int i = 0; i < 9; i++) begin
      Mem_ack = lw_ack[i];
      @(negedge clk);
      check("lw_wait_state", State, lw_seq[4*i +: 4]);
      check("lw_wait_memread", MemRead, lw_rd[i]);
      check("lw_wait_irwrite", IRWrite, lw_irw[i]);
      check("lw_wait_iord", IorD, lw_iord[i]);
      check("lw_wait_memtoreg", {MemtoReg, RegWrite}, {lw_m2r[i], lw_m2r[i]});
      tick();
    end
    check("lw_wait_cycles", Cycle_cnt - c0, 32'd9);
    check("lw_wait_inst", Inst_cnt - i0, 32'd1);
    check("lw_wait_ret", State, S_IF);

    // ---- sw interrupted by reset while waiting in MEM_WR ----
    Opcode = OP_SW; Mem_ack = 1'b1;
    tick();                 // IF acked
    Mem_ack = 1'b0;
    tick();                 // ID
    tick();                 // EX_ADDR
    @(negedge clk);
    check("sw_rst_memwrite", {MemWrite, MemRead, IorD, RegWrite}, 4'b1010);
    check("sw_rst_state", State, S_MEM_WR);
    tick();
    @(negedge clk);
    check("sw_rst_still_wait", State, S_MEM_WR);
    #4;
    rst = 1'b0;             // asserted mid-cycle, before the next edge
    tick();
    check("sw_rst_state_if", State, S_IF);
    check("sw_rst_ctrl", ctrl_bus, 15'd0);
    check("sw_rst_cycle", Cycle_cnt, 32'd0);
    check("sw_rst_inst", Inst_cnt, 32'd0);

    // ---- repeated unknown opcodes; 4-bit counter build wraps ----
    Opcode = 6'b111111; Mem_ack = 1'b1;
    reset_dut(1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("nop_no_write", {RegWrite, MemWrite}, 2'b00);
      tick();
    end
    check("wrap_w4_cycle_15", w4_Cycle_cnt, 4'hF);
    check("wrap_cycle_15", Cycle_cnt, 32'd15);
    tick();
    check("wrap_w4_cycle_0", w4_Cycle_cnt, 4'h0);
    check("wrap_cycle_16", Cycle_cnt, 32'd16);
    check("wrap_inst", Inst_cnt, 32'd8);
    check("wrap_w4_inst", w4_Inst_cnt, 4'd8);
    check("wrap_w4_state", w4_State, S_IF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
